// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle for alu_op_sequencer.
// master = command issuer / response consumer, slave = sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered command front-end and result back-end around a
// combinational ALU, with an accumulator for chained operations.
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_rsp_hs;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  assign w_accept = bus.cmd_valid && w_cmd_ready;
  assign w_rsp_hs = r_rsp_valid && bus.rsp_ready;

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_zero   = ~|r_rsp_result;

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign acc      = r_acc;
  assign op_count = r_op_count;

  // Next state and command-ready; RESP can retire and re-accept together.
  always_comb begin
    w_state_n   = r_state;
    w_cmd_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) w_state_n = EXEC;
      end
      EXEC: w_state_n = RESP;
      RESP: begin
        w_cmd_ready = bus.rsp_ready;
        if (bus.rsp_ready)
          w_state_n = bus.cmd_valid ? EXEC : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Operand capture on accept, result capture after the ALU settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_acc        <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_op <= bus.cmd_op;
        r_alu_b  <= bus.cmd_b;
        r_alu_a  <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
      end
      if (r_state == EXEC) begin
        r_rsp_result <= alu_result;
        r_rsp_carry  <= alu_carry;
        r_acc        <= alu_result;
        r_rsp_valid  <= 1'b1;
      end else if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

endmodule
